// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the register-file dump reader.
package regfile_pkg;

    localparam int NUM_REGS   = 32;
    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = 5;

    // The last register is the hardwired zero register; writes to it are never forwarded.
    localparam logic [ADDR_WIDTH-1:0] ZERO_REG = ADDR_WIDTH'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        HOLD = 2'd2,
        FIN  = 2'd3
    } dump_state_t;

endpackage

// File: rtl/dump_out_reg.sv
// Output holding register for the dump stream: capture, snoop update and clear.
module dump_out_reg #(
    parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  clear,
    input  logic                  snoop,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [ADDR_WIDTH-1:0] load_idx,
    input  logic [DATA_WIDTH-1:0] snoop_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_idx
);

    logic                  valid_reg;
    logic [DATA_WIDTH-1:0] data_reg;
    logic [ADDR_WIDTH-1:0] idx_reg;

    // Clear only drops valid; data/idx keep their last value so the bus stays quiet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            idx_reg   <= '0;
        end else if (clear) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
            data_reg  <= load_data;
            idx_reg   <= load_idx;
        end else if (snoop) begin
            data_reg  <= snoop_data;
        end
    end

    assign out_valid = valid_reg;
    assign out_data  = data_reg;
    assign out_idx   = idx_reg;

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks every register through one read port and streams each word over valid/ready,
// keeping the held word coherent with writes snooped from the register file write port.
module regfile_dump_reader #(
    parameter int NUM_REGS   = regfile_pkg::NUM_REGS,
    parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_idx,
    output logic                  busy,
    output logic                  done
);

    import regfile_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

    dump_state_t           state_reg, state_next;
    logic [ADDR_WIDTH-1:0] idx_reg, idx_next;

    logic out_load;
    logic out_clear;
    logic out_snoop;
    logic accept;

    assign accept = (state_reg == HOLD) && out_ready && !abort;

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        if (abort && state_reg != IDLE) begin
            state_next = IDLE;
            idx_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_next = RD;
                        idx_next   = '0;
                    end
                end
                RD: state_next = HOLD;
                HOLD: begin
                    // Terminal index is checked before incrementing so idx never wraps.
                    if (out_ready) begin
                        if (idx_reg == LAST_IDX) begin
                            state_next = FIN;
                        end else begin
                            state_next = RD;
                            idx_next   = idx_reg + ADDR_WIDTH'(1);
                        end
                    end
                end
                FIN:     state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    // A write landing on the same edge as acceptance is not forwarded: the old word goes out.
    assign out_load  = (state_reg == RD) && !abort;
    assign out_clear = (abort && state_reg != IDLE) || accept;
    assign out_snoop = (state_reg == HOLD) && !out_ready && !abort && wr_en
                       && (wr_addr == out_idx) && (wr_addr != LAST_IDX);

    dump_out_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_out_reg (
        .clk        (clk),
        .reset      (reset),
        .load       (out_load),
        .clear      (out_clear),
        .snoop      (out_snoop),
        .load_data  (rd_data),
        .load_idx   (idx_reg),
        .snoop_data (wr_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_idx    (out_idx)
    );

    assign rd_addr = idx_reg;
    assign busy    = (state_reg != IDLE);
    assign done    = (state_reg == FIN);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader with a small register file model on the read port.
module tb_regfile_dump_reader;

    typedef struct {
        logic [4:0]  idx;
        logic [63:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [4:0]  rd_addr;
    logic [63:0] rd_data;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic [4:0]  out_idx;
    logic        busy;
    logic        done;

    logic [63:0] mem [32];
    logic        preload = 1'b1;
    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          dump_words = 0;

    always #5 clk = ~clk;

    regfile_dump_reader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done)
    );

    // Register file model: reg 31 is hardwired zero.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= (i == 31) ? 64'h0 : 64'h1000 + 64'(i);
        end else if (wr_en && wr_addr != 5'd31) begin
            mem[wr_addr] <= wr_data;
        end
    end
    assign rd_data = mem[rd_addr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Words are accepted at the next rising edge when valid and ready are both high here.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready && !abort) begin
            $display("word idx=%0d data=%h", out_idx, out_data);
            dump_words++;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_word", 64'(out_idx), 64'hFFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_idx", 64'(out_idx), 64'(e.idx));
                check("sb_data", out_data, e.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        exp_q.delete();
        for (int i = 0; i < 32; i++) begin
            exp_t e;
            e.idx  = 5'(i);
            e.data = mem[i];
            exp_q.push_back(e);
        end
        dump_words = 0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic advance_to(input logic [4:0] n);
        bit hit = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 200 && !hit; c++) begin
            step();
            if (out_valid && out_idx == n) hit = 1;
        end
        out_ready = 1'b0;
        if (!hit) check("advance_timeout", 64'(out_idx), 64'(n));
    endtask

    initial begin
        repeat (3) step();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_data", out_data, 64'd0);
        check("rst_idx", 64'(out_idx), 64'd0);
        preload = 1'b0;
        reset = 1'b0;
        step();

        // Full dump with out_ready tied high.
        out_ready = 1'b1;
        do_start();
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_valid_early", 64'(out_valid), 64'd0);
        for (int k = 1; k <= 64; k++) begin
            step();
            if (k == 1)  check("t1_valid_lat", 64'(out_valid), 64'd1);
            if (k == 63) check("t1_done_early", 64'(done), 64'd0);
            if (k == 64) check("t1_done", 64'(done), 64'd1);
        end
        step();
        check("t1_done_pulse", 64'(done), 64'd0);
        check("t1_busy_after", 64'(busy), 64'd0);
        check("t1_words", 64'(dump_words), 64'd32);
        check("t1_queue_left", 64'(exp_q.size()), 64'd0);

        // Backpressure, same-edge accept/write, snoop, abort.
        out_ready = 1'b0;
        do_start();
        advance_to(5'd3);
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_data", out_data, 64'h1003);
            check("bp_idx", 64'(out_idx), 64'd3);
        end
        out_ready = 1'b1;
        step();
        check("bp_rel_valid", 64'(out_valid), 64'd0);
        step();
        out_ready = 1'b0;
        check("bp_next_idx", 64'(out_idx), 64'd4);
        check("bp_next_valid", 64'(out_valid), 64'd1);

        advance_to(5'd5);
        out_ready = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hBEEF;
        step();
        wr_en = 1'b0; out_ready = 1'b0;

        advance_to(5'd7);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'hDEAD;
        exp_q[0].data = 64'hDEAD;
        step();
        check("snoop_hit", out_data, 64'hDEAD);
        wr_addr = 5'd8; wr_data = 64'h8888;
        foreach (exp_q[i]) if (exp_q[i].idx == 5'd8) exp_q[i].data = 64'h8888;
        step();
        check("snoop_other", out_data, 64'hDEAD);
        wr_addr = 5'd31; wr_data = 64'hFFFF;
        step();
        wr_en = 1'b0;
        check("snoop_zero", out_data, 64'hDEAD);
        check("snoop_idx", 64'(out_idx), 64'd7);

        advance_to(5'd10);
        abort = 1'b1;
        out_ready = 1'b1;
        step();
        abort = 1'b0;
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        step();
        check("abort_done_late", 64'(done), 64'd0);
        check("abort_words", 64'(dump_words), 64'd10);

        // Fresh dump after abort; a start while busy must be ignored.
        do_start();
        repeat (5) step();
        start = 1'b1;
        step();
        start = 1'b0;
        begin
            bit seen = 0;
            for (int c = 0; c < 200 && !seen; c++) begin
                step();
                if (done) seen = 1;
            end
            check("t3_done_seen", 64'(seen), 64'd1);
        end
        check("t3_words", 64'(dump_words), 64'd32);
        repeat (3) step();
        check("t3_no_restart", 64'(busy), 64'd0);

        // Asynchronous reset between edges mid-dump.
        do_start();
        repeat (10) step();
        check("t4_busy_pre", 64'(busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("t4_valid", 64'(out_valid), 64'd0);
        check("t4_busy", 64'(busy), 64'd0);
        check("t4_done", 64'(done), 64'd0);
        check("t4_idx", 64'(out_idx), 64'd0);
        exp_q.delete();
        step();
        reset = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
